// File: rtl/rom_stream_reader_if.sv
// Command and output-stream handshake bundle for rom_stream_reader.
// The slave side is the reader; the master side issues commands and sinks words.
interface rom_stream_reader_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 9,
    parameter int LEN_WIDTH  = 13
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [LEN_WIDTH-1:0]  cmd_len;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;

    modport master (
        output cmd_valid, cmd_addr, cmd_len, out_ready,
        input  cmd_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  cmd_valid, cmd_addr, cmd_len, out_ready,
        output cmd_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/rom_stream_reader.sv
// Fetches a run of consecutive words from a 1-cycle-latency block ROM
// and streams them out through a 2-entry skid buffer.
module rom_stream_reader #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 9,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    rom_stream_reader_if.slave    s,
    output logic                  rom_en,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic                  busy
);
    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } state_t;

    typedef struct packed {
        logic                  last;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [LEN_WIDTH-1:0]  issue_cnt;
    logic [LEN_WIDTH-1:0]  out_cnt;
    logic                  inflight;
    logic                  inflight_last;

    entry_t                fifo [2];
    logic                  rd_ptr;
    logic                  wr_ptr;
    logic [1:0]            occ;

    logic                  pop;
    logic                  push;
    logic [2:0]            load;

    assign pop  = (occ != 2'd0) && s.out_ready;
    assign push = inflight;

    // Words already committed to the buffer after this cycle's pop.
    assign load = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};

    assign rom_en = (state == FETCH)
                 && (issue_cnt != '0)
                 && (load < 3'd2);
    assign rom_addr = addr;

    assign s.cmd_ready = (state == IDLE);
    assign s.out_valid = (occ != 2'd0);
    assign s.out_data  = fifo[rd_ptr].data;
    assign s.out_last  = fifo[rd_ptr].last;
    assign busy        = (state != IDLE) || (occ != 2'd0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            addr          <= '0;
            issue_cnt     <= '0;
            out_cnt       <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (s.cmd_valid) begin
                        addr      <= s.cmd_addr;
                        issue_cnt <= s.cmd_len;
                        out_cnt   <= s.cmd_len;
                        if (s.cmd_len != '0) begin
                            state <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    if (rom_en && issue_cnt == LEN_WIDTH'(1)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && out_cnt == LEN_WIDTH'(1)) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (rom_en) begin
                addr      <= addr + ADDR_WIDTH'(1);
                issue_cnt <= issue_cnt - LEN_WIDTH'(1);
            end
            if (pop && state != IDLE) begin
                out_cnt <= out_cnt - LEN_WIDTH'(1);
            end
            inflight      <= rom_en;
            inflight_last <= rom_en && (issue_cnt == LEN_WIDTH'(1));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fifo[0] <= '0;
            fifo[1] <= '0;
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            occ     <= 2'd0;
        end else begin
            // ROM has no output register, so douta is captured the cycle it appears.
            if (push) begin
                fifo[wr_ptr] <= '{last: inflight_last, data: rom_data};
                wr_ptr       <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            occ <= occ + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// File: tb/tb_rom_stream_reader.sv
// Directed and randomized bench for rom_stream_reader with a behavioural
// ROM and a queue-based reference of the expected word stream.
module tb_rom_stream_reader;
    localparam int AW    = 12;
    localparam int DW    = 9;
    localparam int LW    = 13;
    localparam int DEPTH = 1 << AW;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } word_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          rom_en;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    logic          busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [DW-1:0] rom [DEPTH];

    word_t         rcv [$];
    logic [AW-1:0] iss_addr [$];
    int            first_valid_cyc = -1;
    int            last_pop_cyc = -1;
    int            outst = 0;
    logic          mon_pop;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;

    always #5 clk = ~clk;

    rom_stream_reader_if #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .LEN_WIDTH (LW)
    ) bus ();

    rom_stream_reader #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .LEN_WIDTH (LW)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .s       (bus),
        .rom_en  (rom_en),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .busy    (busy)
    );

    always @(posedge clk) begin
        if (rom_en) rom_data <= rom[rom_addr];
    end

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Observer: everything here is sampled mid-cycle, ahead of the next edge.
    always @(negedge clk) begin
        if (!reset_n) begin
            outst      = 0;
            prev_stall = 1'b0;
        end else begin
            mon_pop = bus.out_valid && bus.out_ready;
            if (bus.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (prev_stall) begin
                check("stall_valid", 32'(bus.out_valid), 32'd1);
                check("stall_data", 32'(bus.out_data), 32'(prev_data));
                check("stall_last", 32'(bus.out_last), 32'(prev_last));
            end
            if (rom_en) begin
                check("no_overissue", 32'((outst - int'(mon_pop)) < 2), 32'd1);
                iss_addr.push_back(rom_addr);
            end
            if (mon_pop) begin
                rcv.push_back('{bus.out_data, bus.out_last});
                last_pop_cyc = cyc + 1;
            end
            outst      = outst + int'(rom_en) - int'(mon_pop);
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            prev_last  = bus.out_last;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!bus.cmd_ready && n < 200) begin
            step();
            n++;
        end
        if (!bus.cmd_ready) check({tag, "_ready_timeout"}, 32'd0, 32'd1);
    endtask

    // rmode: 0 = always ready, 1 = 1,0,0,1 pattern, 2 = random
    task automatic run_cmd(input string tag, input logic [AW-1:0] a,
                           input int len, input int rmode, input bit timing);
        word_t exp_q [$];
        int    acc;
        int    budget;
        int    c;
        for (int k = 0; k < len; k++) begin
            exp_q.push_back('{rom[(int'(a) + k) % DEPTH], k == len - 1});
        end
        wait_ready(tag);
        rcv.delete();
        iss_addr.delete();
        first_valid_cyc = -1;
        bus.cmd_addr  = a;
        bus.cmd_len   = LW'(len);
        bus.cmd_valid = 1'b1;
        bus.out_ready = 1'b1;
        step();
        acc = cyc;
        bus.cmd_valid = 1'b0;
        budget = len * 8 + 50;
        c = 0;
        while (rcv.size() < len && c < budget) begin
            case (rmode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = !((c % 4) == 1 || (c % 4) == 2);
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
            step();
            c++;
        end
        if (rcv.size() < len) check({tag, "_timeout"}, 32'(rcv.size()), 32'(len));
        check({tag, "_ready_after"}, 32'(bus.cmd_ready), 32'd1);
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        check({tag, "_count"}, 32'(rcv.size()), 32'(len));
        check({tag, "_issues"}, 32'(iss_addr.size()), 32'(len));
        for (int k = 0; k < len && k < rcv.size(); k++) begin
            check($sformatf("%s_data[%0d]", tag, k), 32'(rcv[k].d), 32'(exp_q[k].d));
            check($sformatf("%s_last[%0d]", tag, k), 32'(rcv[k].l), 32'(exp_q[k].l));
        end
        for (int k = 0; k < len && k < iss_addr.size(); k++) begin
            check($sformatf("%s_addr[%0d]", tag, k), 32'(iss_addr[k]),
                  32'((int'(a) + k) % DEPTH));
        end
        if (timing) begin
            check({tag, "_first_lat"}, 32'(first_valid_cyc - acc), 32'd2);
            check({tag, "_total"}, 32'(last_pop_cyc - acc), 32'(len + 2));
        end
        bus.out_ready = 1'b1;
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) rom[i] = DW'(i);

        repeat (3) step();
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_rom_en", 32'(rom_en), 32'd0);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_out_last", 32'(bus.out_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        repeat (2) step();

        run_cmd("basic", 12'h010, 4, 0, 1'b1);
        run_cmd("wrap", 12'hFFE, 4, 0, 1'b1);
        run_cmd("bp", 12'h123, 8, 1, 1'b0);

        wait_ready("zero");
        bus.cmd_addr  = 12'h055;
        bus.cmd_len   = '0;
        bus.cmd_valid = 1'b1;
        step();
        bus.cmd_valid = 1'b0;
        check("zero_ready", 32'(bus.cmd_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            check("zero_rom_en", 32'(rom_en), 32'd0);
            check("zero_valid", 32'(bus.out_valid), 32'd0);
            check("zero_busy", 32'(busy), 32'd0);
            step();
        end

        run_cmd("sweep", 12'h000, DEPTH, 0, 1'b1);

        wait_ready("rst");
        bus.cmd_addr  = 12'h100;
        bus.cmd_len   = LW'(8);
        bus.cmd_valid = 1'b1;
        step();
        bus.cmd_valid = 1'b0;
        bus.out_ready = 1'b0;
        step();
        step();
        check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        check("pre_rst_busy", 32'(busy), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("mid_rst_rom_en", 32'(rom_en), 32'd0);
        check("mid_rst_rom_addr", 32'(rom_addr), 32'd0);
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_data", 32'(bus.out_data), 32'd0);
        check("mid_rst_last", 32'(bus.out_last), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        repeat (2) step();
        reset_n = 1'b1;
        rcv.delete();
        bus.out_ready = 1'b1;
        repeat (5) step();
        check("post_rst_stale", 32'(rcv.size()), 32'd0);
        check("post_rst_valid", 32'(bus.out_valid), 32'd0);
        run_cmd("fresh", 12'h2A5, 1, 0, 1'b1);

        for (int i = 0; i < DEPTH; i++) rom[i] = DW'($urandom);
        for (int t = 0; t < 12; t++) begin
            logic [AW-1:0] ra;
            int            rl;
            ra = (t % 3 == 0) ? AW'(DEPTH - $urandom_range(1, 8))
                              : AW'($urandom);
            rl = $urandom_range(1, 24);
            run_cmd($sformatf("rnd%0d", t), ra, rl, 2, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
